// File: rtl/opl2_pkg.sv
// ---------------------------------------------------------------------------
// opl2_pkg
// Shared constants and types for the OPL2 timer control/status stage:
//   - register addresses of the Timer 1/2 presets and the timer control reg
//   - bit positions inside the timer control register (0x04)
//   - packed layout of the host-visible status byte
// ---------------------------------------------------------------------------
package opl2_pkg;

    localparam int REG_TIMER_WIDTH = 8;

    localparam logic [7:0] REG_TIMER1_ADDR     = 8'h02;
    localparam logic [7:0] REG_TIMER2_ADDR     = 8'h03;
    localparam logic [7:0] REG_TIMER_CTRL_ADDR = 8'h04;

    // Bit positions inside register 0x04.
    localparam int IRQ_RESET_BIT = 7;
    localparam int MASK1_BIT     = 6;
    localparam int MASK2_BIT     = 5;
    localparam int ST2_BIT       = 1;
    localparam int ST1_BIT       = 0;

    // Status byte as seen by the host: {irq, t1_flag, t2_flag, 5'b0}.
    typedef struct packed {
        logic       irq;
        logic       t1_flag;
        logic       t2_flag;
        logic [4:0] rsvd;
    } opl2_status_t;

endpackage

// File: rtl/opl2_irq_flag.sv
// ---------------------------------------------------------------------------
// opl2_irq_flag
// One sticky timer overflow flag together with its mask bit.
//   clk            system clock
//   reset_n        synchronous active-low reset
//   overflow_pulse one-cycle overflow from the timer instance
//   irq_reset      clear request (IRQ reset write)
//   mask_wr        control write that loads the mask bit
//   mask_din       mask value carried by that write
//   flag           registered flag
//   flag_next      flag value being loaded on this edge (for status)
// An unmasked overflow always wins over a same-cycle clear, so no event is
// lost. The mask gating uses the mask value from before this edge.
// ---------------------------------------------------------------------------
module opl2_irq_flag (
    input  logic clk,
    input  logic reset_n,
    input  logic overflow_pulse,
    input  logic irq_reset,
    input  logic mask_wr,
    input  logic mask_din,
    output logic flag,
    output logic flag_next
);

    logic mask;
    logic set_ev;
    logic clear_ev;

    // NOTE: combinational outputs get a default first so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        set_ev    = overflow_pulse & ~mask;
        clear_ev  = irq_reset | (mask_wr & mask_din);
        flag_next = flag;
        if (set_ev) begin
            flag_next = 1'b1;
        end else if (clear_ev) begin
            flag_next = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flag <= 1'b0;
            mask <= 1'b0;
        end else begin
            flag <= flag_next;
            if (mask_wr) begin
                mask <= mask_din;
            end
        end
    end

endmodule

// File: rtl/opl2_timer_ctrl.sv
// ---------------------------------------------------------------------------
// opl2_timer_ctrl
// Host-facing control/status stage for the two OPL2 interval timers.
//   clk, reset_n            clock, synchronous active-low reset
//   wr_en, a0, din          host write strobe, address/data select, data
//   timer1/2_overflow_pulse one-cycle overflow pulses from the timers
//   timer1_reg, timer2_reg  preset values (regs 0x02 / 0x03)
//   start_timer1/2          start levels (reg 0x04 bits 0/1)
//   status                  {irq, t1_flag, t2_flag, 5'b0}, registered
//   irq_n                   active-low interrupt, registered
// ---------------------------------------------------------------------------
module opl2_timer_ctrl
    import opl2_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic                       a0,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       timer1_overflow_pulse,
    input  logic                       timer2_overflow_pulse,
    output logic [REG_TIMER_WIDTH-1:0] timer1_reg,
    output logic [REG_TIMER_WIDTH-1:0] timer2_reg,
    output logic                       start_timer1,
    output logic                       start_timer2,
    output logic [7:0]                 status,
    output logic                       irq_n
);

    logic [ADDR_WIDTH-1:0] addr_q;
    opl2_status_t          status_q;
    opl2_status_t          status_next;

    logic addr_wr;
    logic data_wr;
    logic ctrl_wr;
    logic irq_reset_wr;
    logic mask_wr;
    logic t1_flag;
    logic t2_flag;
    logic t1_flag_next;
    logic t2_flag_next;

    assign addr_wr      = wr_en & ~a0;
    assign data_wr      = wr_en & a0;
    assign ctrl_wr      = data_wr && (addr_q == ADDR_WIDTH'(REG_TIMER_CTRL_ADDR));
    // Bit 7 selects between "IRQ reset" and "load masks/start bits".
    assign irq_reset_wr = ctrl_wr & din[IRQ_RESET_BIT];
    assign mask_wr      = ctrl_wr & ~din[IRQ_RESET_BIT];

    opl2_irq_flag u_flag_t1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .overflow_pulse (timer1_overflow_pulse),
        .irq_reset      (irq_reset_wr),
        .mask_wr        (mask_wr),
        .mask_din       (din[MASK1_BIT]),
        .flag           (t1_flag),
        .flag_next      (t1_flag_next)
    );

    opl2_irq_flag u_flag_t2 (
        .clk            (clk),
        .reset_n        (reset_n),
        .overflow_pulse (timer2_overflow_pulse),
        .irq_reset      (irq_reset_wr),
        .mask_wr        (mask_wr),
        .mask_din       (din[MASK2_BIT]),
        .flag           (t2_flag),
        .flag_next      (t2_flag_next)
    );

    // Status is built from the flags' next state so an overflow shows up on
    // the same edge the flag is set, i.e. one cycle after the pulse.
    always_comb begin
        status_next         = '0;
        status_next.t1_flag = t1_flag_next;
        status_next.t2_flag = t2_flag_next;
        status_next.irq     = t1_flag_next | t2_flag_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q       <= '0;
            timer1_reg   <= '0;
            timer2_reg   <= '0;
            start_timer1 <= 1'b0;
            start_timer2 <= 1'b0;
            status_q     <= '0;
            irq_n        <= 1'b1;
        end else begin
            if (addr_wr) begin
                addr_q <= din[ADDR_WIDTH-1:0];
            end
            if (data_wr && (addr_q == ADDR_WIDTH'(REG_TIMER1_ADDR))) begin
                timer1_reg <= REG_TIMER_WIDTH'(din);
            end
            if (data_wr && (addr_q == ADDR_WIDTH'(REG_TIMER2_ADDR))) begin
                timer2_reg <= REG_TIMER_WIDTH'(din);
            end
            if (mask_wr) begin
                start_timer1 <= din[ST1_BIT];
                start_timer2 <= din[ST2_BIT];
            end
            status_q <= status_next;
            irq_n    <= ~status_next.irq;
        end
    end

    assign status = status_q;

    // Flags are only observed through status; keep the registered copies
    // referenced so the hierarchy stays self-describing.
    logic unused_flags;
    assign unused_flags = t1_flag ^ t2_flag;

endmodule
